// File: rtl/timer_irq_bus_pkg.sv
// Shared constants for the memory-mapped tick timer.
//
// Contents:
//   TMR_BASE        - ram_addr[31:28] region that selects the timer at top level
//   TMR_CTRL..      - register offsets, compared against addr[3:2]
//   CTRL_*          - bit positions inside the CTRL register
//   tmr_region_hit  - top-level decode helper for a full 32-bit data address
package timer_irq_bus_pkg;

  localparam logic [3:0] TMR_BASE = 4'hC;

  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_LOAD   = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_RELOAD  = 1;
  localparam int unsigned CTRL_IE      = 2;
  localparam int unsigned CTRL_PRE_LSB = 8;

  // True when a CPU data address falls in the timer's region.
  function automatic logic tmr_region_hit(input logic [31:0] ram_addr);
    return ram_addr[31:28] == TMR_BASE;
  endfunction

endpackage

// File: rtl/timer_irq_bus_if.sv
// Simple slave bus shared by the gpio, uart and timer peripherals.
//
// Signals:
//   ce   - slave select, one-cycle strobe per access
//   we   - 1 = write, 0 = read, qualified by ce
//   addr - byte address within the slave
//   din  - write data from the master
//   dout - registered read data from the slave, valid the cycle after ce
interface timer_irq_bus_if;

  logic        ce;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (
    output ce,
    output we,
    output addr,
    output din,
    input  dout
  );

  modport slave (
    input  ce,
    input  we,
    input  addr,
    input  din,
    output dout
  );

endinterface

// File: rtl/timer_prescaler.sv
// Prescaler for the tick timer: divides clk by (pre + 1).
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   en   - count enable; the counter holds while low
//   clr  - synchronous restart of the counter from 0, overrides en
//   pre  - terminal value; a tick fires on the cycle the counter equals it
//   tick - one-cycle pulse, combinational from the current counter state
module timer_prescaler #(
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] pre,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q, cnt_d;
  logic             at_term;

  assign at_term = (cnt_q == pre);

  // A restart suppresses the tick so a colliding register write wins.
  assign tick = en & ~clr & at_term;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_term ? '0 : cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_irq_bus.sv
// Memory-mapped down-counting timer with a level interrupt to the core.
//
// Register map (addr[3:2]):
//   0 CTRL   RW  bit0 EN, bit1 RELOAD, bit2 IE, bits[8 +: PRE_W] PRE
//   1 LOAD   RW  reload value; writing it also loads COUNT and restarts the prescaler
//   2 COUNT  RO  current count
//   3 STATUS     bit0 EXP, write 1 to clear
//
// Ports:
//   clk - system clock
//   rst - asynchronous active-high reset
//   bus - slave side of the peripheral bus (ce, we, addr, din, dout)
//   irq - registered level interrupt, EXP & IE
module timer_irq_bus
  import timer_irq_bus_pkg::*;
#(
  parameter int unsigned PRE_W = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  timer_irq_bus_if.slave     bus,
  output logic               irq
);

  // Register state
  logic             en_q, en_d;
  logic             reload_q, reload_d;
  logic             ie_q, ie_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             exp_q, exp_d;
  logic [31:0]      dout_q, dout_d;
  logic             irq_q, irq_d;

  // Access decode
  logic       wr, rd;
  logic [1:0] sel;
  logic       ctrl_wr, load_wr, status_wr;
  logic       unused_addr;

  assign wr        = bus.ce & bus.we;
  assign rd        = bus.ce & ~bus.we;
  assign sel       = bus.addr[3:2];
  assign ctrl_wr   = wr & (sel == TMR_CTRL);
  assign load_wr   = wr & (sel == TMR_LOAD);
  assign status_wr = wr & (sel == TMR_STATUS);

  // Registers are word aligned; the byte offset is ignored.
  assign unused_addr = ^bus.addr[1:0];

  // Prescaler control. A CTRL write clearing EN stops the prescaler on the same edge
  // so a coincident tick has no effect; a LOAD write or an EN 0->1 write restarts it.
  logic pre_en, pre_clr, tick;

  assign pre_en  = en_q & ~(ctrl_wr & ~bus.din[CTRL_EN]);
  assign pre_clr = load_wr | (ctrl_wr & bus.din[CTRL_EN] & ~en_q);

  timer_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .pre  (pre_q),
    .tick (tick)
  );

  // Read data mux; COUNT returns the value before this edge.
  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    unique case (sel)
      TMR_CTRL: begin
        rd_data[CTRL_EN]                  = en_q;
        rd_data[CTRL_RELOAD]              = reload_q;
        rd_data[CTRL_IE]                  = ie_q;
        rd_data[CTRL_PRE_LSB +: PRE_W]    = pre_q;
      end
      TMR_LOAD:   rd_data[CNT_W-1:0] = load_q;
      TMR_COUNT:  rd_data[CNT_W-1:0] = count_q;
      TMR_STATUS: rd_data[0]         = exp_q;
    endcase
  end

  // Next-state logic. Ordering of the statements encodes the collision priorities:
  // tick effects first, then register writes override them.
  logic exp_set;

  always_comb begin
    en_d     = en_q;
    reload_d = reload_q;
    ie_d     = ie_q;
    pre_d    = pre_q;
    load_d   = load_q;
    count_d  = count_q;
    exp_d    = exp_q;
    exp_set  = 1'b0;

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        exp_set = 1'b1;
        if (reload_q) begin
          count_d = load_q;
        end else begin
          // One-shot: park at zero and stop.
          en_d = 1'b0;
        end
      end
    end

    if (status_wr && bus.din[0]) begin
      exp_d = 1'b0;
    end
    // A new expiry beats a clear in the same cycle.
    if (exp_set) begin
      exp_d = 1'b1;
    end

    if (ctrl_wr) begin
      en_d     = bus.din[CTRL_EN];
      reload_d = bus.din[CTRL_RELOAD];
      ie_d     = bus.din[CTRL_IE];
      pre_d    = bus.din[CTRL_PRE_LSB +: PRE_W];
    end

    // pre_clr already blocks the tick, so COUNT takes din without a decrement.
    if (load_wr) begin
      load_d  = bus.din[CNT_W-1:0];
      count_d = bus.din[CNT_W-1:0];
    end

    irq_d  = exp_d & ie_d;
    dout_d = rd ? rd_data : dout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      ie_q     <= 1'b0;
      pre_q    <= '0;
      load_q   <= '0;
      count_q  <= '0;
      exp_q    <= 1'b0;
      dout_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      reload_q <= reload_d;
      ie_q     <= ie_d;
      pre_q    <= pre_d;
      load_q   <= load_d;
      count_q  <= count_d;
      exp_q    <= exp_d;
      dout_q   <= dout_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.dout = dout_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_timer_irq_bus.sv
// Scoreboard bench for timer_irq_bus. Stimulus pushes expected read data and
// expected irq/dout probes into queues; a single monitor process owns all
// comparisons and the summary.
module tb_timer_irq_bus;

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_LOAD   = 4'h4;
  localparam logic [3:0] A_COUNT  = 4'h8;
  localparam logic [3:0] A_STATUS = 4'hC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;

  timer_irq_bus_if bus_if ();

  timer_irq_bus #(
    .PRE_W (8),
    .CNT_W (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if),
    .irq (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_irq;
    logic [31:0] val;
  } exp_t;

  exp_t rd_q[$];
  exp_t pr_q[$];
  logic rd_seen    = 1'b0;
  bit   stim_done  = 1'b0;
  int   checks     = 0;
  int   errors     = 0;

  always @(posedge clk) rd_seen <= bus_if.ce & ~bus_if.we;

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_if.ce   = 1'b1;
    bus_if.we   = 1'b1;
    bus_if.addr = a;
    bus_if.din  = d;
    @(posedge clk);
    #1;
    bus_if.ce = 1'b0;
    bus_if.we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] e, input string n);
    rd_q.push_back('{name: n, is_irq: 1'b0, val: e});
    bus_if.ce   = 1'b1;
    bus_if.we   = 1'b0;
    bus_if.addr = a;
    @(posedge clk);
    #1;
    bus_if.ce = 1'b0;
  endtask

  task automatic probe_irq(input logic e, input string n);
    pr_q.push_back('{name: n, is_irq: 1'b1, val: {31'b0, e}});
  endtask

  task automatic probe_dout(input logic [31:0] e, input string n);
    pr_q.push_back('{name: n, is_irq: 1'b0, val: e});
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    int          drain;
    drain = 0;
    forever begin
      @(negedge clk);
      if (rd_seen) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read: dout=%h with nothing expected", bus_if.dout);
        end else begin
          e = rd_q.pop_front();
          if (bus_if.dout !== e.val) begin
            errors++;
            $display("FAIL %s: dout=%h expected %h", e.name, bus_if.dout, e.val);
          end
        end
      end
      while (pr_q.size() != 0) begin
        e   = pr_q.pop_front();
        act = e.is_irq ? {31'b0, irq} : bus_if.dout;
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
      if (stim_done) begin
        drain++;
        if ((rd_q.size() == 0 && pr_q.size() == 0) || drain > 4) begin
          if (rd_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d reads never answered", rd_q.size());
          end
          $display("CHECKS %0d ERRORS %0d", checks, errors);
          $finish;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    bus_if.ce   = 1'b0;
    bus_if.we   = 1'b0;
    bus_if.addr = 4'h0;
    bus_if.din  = 32'h0;

    // Reset values; a write-looking cycle with ce=0 must be ignored.
    repeat (3) @(posedge clk);
    #1;
    probe_dout(32'h0, "rst_dout");
    probe_irq(1'b0, "rst_irq");
    rst = 1'b0;
    bus_if.we   = 1'b1;
    bus_if.addr = A_CTRL;
    bus_if.din  = 32'h0000_0007;
    idle(1);
    bus_if.we = 1'b0;
    bus_read(A_CTRL,   32'h0, "rst_ctrl");
    bus_read(A_LOAD,   32'h0, "rst_load");
    bus_read(A_COUNT,  32'h0, "rst_count");
    bus_read(A_STATUS, 32'h0, "rst_status");
    probe_irq(1'b0, "rst_irq_after");

    // Auto-reload, PRE=0: LOAD=4, EN at E1, expiry on E6.
    bus_write(A_LOAD, 32'd4);
    bus_write(A_CTRL, 32'h0000_0007);
    idle(3);                                        // E2..E4
    bus_read(A_STATUS, 32'h0, "ar_exp_e5");         // E5
    probe_irq(1'b0, "ar_irq_before");
    bus_read(A_STATUS, 32'h0, "ar_exp_pre_e6");     // E6, pre-edge value
    probe_irq(1'b1, "ar_irq_rise");
    bus_read(A_COUNT, 32'd4, "ar_count_reload");    // E7
    bus_read(A_STATUS, 32'h1, "ar_exp_set");        // E8
    bus_write(A_CTRL, 32'h0);                       // E9, EN off beats tick
    bus_write(A_STATUS, 32'h1);                     // E10
    probe_irq(1'b0, "ar_irq_cleared");
    bus_read(A_STATUS, 32'h0, "ar_exp_cleared");
    bus_read(A_COUNT, 32'd2, "ar_count_frozen");

    // Prescaled one-shot: LOAD=2, PRE=3, expiry 12 cycles after EN.
    bus_write(A_LOAD, 32'd2);                       // F0
    bus_write(A_CTRL, 32'h0000_0301);               // F1
    idle(6);                                        // F2..F7
    bus_read(A_COUNT, 32'd1, "os_count_mid");       // F8
    idle(4);                                        // F9..F12
    bus_read(A_STATUS, 32'h0, "os_exp_pre_f13");    // F13
    bus_read(A_STATUS, 32'h1, "os_exp_set");        // F14
    bus_read(A_CTRL, 32'h0000_0300, "os_en_cleared");
    bus_read(A_COUNT, 32'd0, "os_count_zero");
    probe_irq(1'b0, "os_irq_masked");
    idle(3);
    bus_read(A_COUNT, 32'd0, "os_count_stays");
    bus_write(A_STATUS, 32'h1);

    // Clear vs set race: LOAD=0, RELOAD, PRE=0 expires every cycle.
    bus_write(A_LOAD, 32'd0);
    bus_write(A_CTRL, 32'h0000_0007);
    for (int i = 0; i < 4; i++) begin
      bus_write(A_STATUS, 32'h1);
      probe_irq(1'b1, "race_irq");
    end
    bus_read(A_STATUS, 32'h1, "race_exp");
    bus_write(A_CTRL, 32'h0000_0004);
    probe_irq(1'b1, "race_irq_ie_only");
    bus_write(A_STATUS, 32'h1);
    probe_irq(1'b0, "race_irq_cleared");
    bus_read(A_STATUS, 32'h0, "race_exp_cleared");

    // LOAD write collides with a due tick: PRE=1, COUNT=1 at H5.
    bus_write(A_LOAD, 32'd2);                       // H0
    bus_write(A_CTRL, 32'h0000_0101);               // H1
    idle(2);                                        // H2, H3 (tick -> 1)
    bus_read(A_COUNT, 32'd1, "col_count_one");      // H4
    bus_write(A_LOAD, 32'd10);                      // H5, tick due
    bus_read(A_STATUS, 32'h0, "col_no_expiry");     // H6
    bus_read(A_COUNT, 32'd10, "col_count_loaded");  // H7, H6 had no tick
    bus_read(A_COUNT, 32'd9, "col_count_dec");      // H8
    probe_irq(1'b0, "col_irq");
    bus_write(A_CTRL, 32'h0);
    bus_read(A_LOAD, 32'd10, "col_load");

    // Asynchronous reset while irq=1 and COUNT=7.
    bus_write(A_LOAD, 32'd0);
    bus_write(A_CTRL, 32'h0000_0005);
    idle(1);                                        // one-shot expiry, irq rises
    bus_write(A_LOAD, 32'd7);
    probe_irq(1'b1, "ar_setup_irq");
    bus_read(A_COUNT, 32'd7, "ar_setup_count");
    idle(1);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    probe_irq(1'b0, "async_irq");
    probe_dout(32'h0, "async_dout");
    bus_read(A_CTRL,   32'h0, "async_ctrl");
    bus_read(A_LOAD,   32'h0, "async_load");
    bus_read(A_COUNT,  32'h0, "async_count");
    bus_read(A_STATUS, 32'h0, "async_status");
    probe_irq(1'b0, "async_irq_after");

    stim_done = 1'b1;
  end

endmodule
